// File: rtl/hdmi_rx_scdc_regs_if.sv
// hdmi_rx_scdc_regs_if
// Register-access bus between the SCDC I2C slave (master side) and the
// SCDC register block (slave side).
//   scdc_i2c_addr  : register offset
//   scdc_i2c_wdata : write data, sampled with scdc_i2c_w
//   scdc_i2c_w     : one-cycle write strobe
//   scdc_i2c_r     : one-cycle read strobe
//   scdc_i2c_rdata : registered read data, valid the cycle after scdc_i2c_r
interface hdmi_rx_scdc_regs_if;
  logic [7:0] scdc_i2c_addr;
  logic [7:0] scdc_i2c_wdata;
  logic       scdc_i2c_w;
  logic       scdc_i2c_r;
  logic [7:0] scdc_i2c_rdata;

  modport master (
    output scdc_i2c_addr,
    output scdc_i2c_wdata,
    output scdc_i2c_w,
    output scdc_i2c_r,
    input  scdc_i2c_rdata
  );

  modport slave (
    input  scdc_i2c_addr,
    input  scdc_i2c_wdata,
    input  scdc_i2c_w,
    input  scdc_i2c_r,
    output scdc_i2c_rdata
  );
endinterface

// File: rtl/hdmi_rx_scdc_regs.sv
// hdmi_rx_scdc_regs
// SCDC register block for the HDMI receiver, 1..4 TMDS/FRL lanes.
// Holds Source_Version / TMDS_Config, the Update_0 flags (W1C), the
// status flag snapshot and per-lane 15-bit saturating character-error
// counters with a coherent low/high byte readout.
// Ports:
//   scdc_i2c_clk         : block clock
//   reset                : asynchronous active-high reset
//   i2c                  : register bus (slave modport)
//   in_5v_power          : source +5V present; low clears source config
//   clk_det              : TMDS clock detected
//   in_lock[NUM_CH]      : per-lane lock
//   char_err[NUM_CH]     : per-lane character-error pulse
//   scrambled_det        : scrambled data detected
//   TMDS_Bit_clock_Ratio : TMDS_Config bit 1
//   scrambling_en        : TMDS_Config bit 0
//   update_pending       : OR of Update_0 bits
module hdmi_rx_scdc_regs #(
  parameter int         NUM_CH       = 3,
  parameter logic [7:0] SINK_VERSION = 8'h01
) (
  input  logic                scdc_i2c_clk,
  input  logic                reset,
  hdmi_rx_scdc_regs_if.slave  i2c,
  input  logic                in_5v_power,
  input  logic                clk_det,
  input  logic [NUM_CH-1:0]   in_lock,
  input  logic [NUM_CH-1:0]   char_err,
  input  logic                scrambled_det,
  output logic                TMDS_Bit_clock_Ratio,
  output logic                scrambling_en,
  output logic                update_pending
);

  localparam logic [7:0]  ADDR_SINK_VER  = 8'h01;
  localparam logic [7:0]  ADDR_SRC_VER   = 8'h02;
  localparam logic [7:0]  ADDR_UPDATE_0  = 8'h10;
  localparam logic [7:0]  ADDR_TMDS_CFG  = 8'h20;
  localparam logic [7:0]  ADDR_SCR_STAT  = 8'h21;
  localparam logic [7:0]  ADDR_STATUS_0  = 8'h40;
  localparam logic [14:0] CNT_MAX        = 15'h7FFF;

  // Low-byte address of lane k's character-error counter.
  function automatic logic [7:0] lane_lo_addr(input int k);
    return 8'(32'h50 + 2 * k);
  endfunction

  logic [7:0]        source_version;
  logic [1:0]        tmds_config;
  logic [1:0]        update_0;      // [1] CED_Update, [0] Status_Update
  logic [7:0]        flags_q;
  logic [7:0]        rdata_q;
  logic [14:0]       ced_cnt    [NUM_CH];
  logic [6:0]        ced_shadow [NUM_CH];

  logic [7:0]        status_flags;
  logic [NUM_CH-1:0] lo_rd;
  logic [NUM_CH-1:0] hi_rd;
  logic [NUM_CH-1:0] cnt_inc;
  logic              ced_set;
  logic              status_set;
  logic [1:0]        upd_clr;
  logic              wr_src;
  logic              wr_cfg;
  logic [7:0]        rd_mux;

  // Status_Flags_0 as seen on the bus; lane bits above NUM_CH stay 0.
  always_comb begin
    status_flags    = 8'h00;
    status_flags[0] = clk_det;
    for (int k = 0; k < NUM_CH; k++) begin
      status_flags[1 + k] = in_lock[k];
    end
  end

  // Per-lane read decode and increment qualification. A clearing
  // high-byte read still accepts a concurrent error, so the counter
  // restarts at 1 instead of losing that event.
  always_comb begin
    lo_rd   = '0;
    hi_rd   = '0;
    cnt_inc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lo_rd[k]   = i2c.scdc_i2c_r && (i2c.scdc_i2c_addr == lane_lo_addr(k));
      hi_rd[k]   = i2c.scdc_i2c_r &&
                   (i2c.scdc_i2c_addr == (lane_lo_addr(k) + 8'd1));
      cnt_inc[k] = char_err[k] && in_lock[k] &&
                   (hi_rd[k] || (ced_cnt[k] != CNT_MAX));
    end
  end

  assign ced_set    = |cnt_inc;
  assign status_set = (status_flags != flags_q);

  always_comb begin
    upd_clr = 2'b00;
    if (i2c.scdc_i2c_w && (i2c.scdc_i2c_addr == ADDR_UPDATE_0)) begin
      upd_clr = i2c.scdc_i2c_wdata[1:0];
    end
  end

  assign wr_src = i2c.scdc_i2c_w && (i2c.scdc_i2c_addr == ADDR_SRC_VER);
  assign wr_cfg = i2c.scdc_i2c_w && (i2c.scdc_i2c_addr == ADDR_TMDS_CFG);

  // Read mux works on pre-edge register values, so a read coinciding
  // with a write to the same offset returns the old contents.
  always_comb begin
    rd_mux = 8'h00;
    case (i2c.scdc_i2c_addr)
      ADDR_SINK_VER: rd_mux = SINK_VERSION;
      ADDR_SRC_VER:  rd_mux = source_version;
      ADDR_UPDATE_0: rd_mux = {6'b0, update_0};
      ADDR_TMDS_CFG: rd_mux = {6'b0, tmds_config};
      ADDR_SCR_STAT: rd_mux = {7'b0, scrambled_det};
      ADDR_STATUS_0: rd_mux = status_flags;
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (i2c.scdc_i2c_addr == lane_lo_addr(k)) begin
            rd_mux = ced_cnt[k][7:0];
          end
          if (i2c.scdc_i2c_addr == (lane_lo_addr(k) + 8'd1)) begin
            rd_mux = {in_lock[k], ced_shadow[k]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge scdc_i2c_clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 8'h00;
    end else if (i2c.scdc_i2c_r) begin
      rdata_q <= rd_mux;
    end
  end

  // Source configuration only exists while the source powers the link.
  always_ff @(posedge scdc_i2c_clk or posedge reset) begin
    if (reset) begin
      source_version <= 8'h00;
      tmds_config    <= 2'b00;
    end else if (!in_5v_power) begin
      source_version <= 8'h00;
      tmds_config    <= 2'b00;
    end else begin
      if (wr_src) begin
        source_version <= i2c.scdc_i2c_wdata;
      end
      if (wr_cfg) begin
        tmds_config <= i2c.scdc_i2c_wdata[1:0];
      end
    end
  end

  // Update_0: a new event wins over a W1C clear landing on the same edge.
  always_ff @(posedge scdc_i2c_clk or posedge reset) begin
    if (reset) begin
      update_0 <= 2'b00;
      flags_q  <= 8'h00;
    end else begin
      update_0 <= {ced_set, status_set} | (update_0 & ~upd_clr);
      flags_q  <= status_flags;
    end
  end

  always_ff @(posedge scdc_i2c_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ced_cnt[k]    <= 15'h0000;
        ced_shadow[k] <= 7'h00;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (lo_rd[k]) begin
          ced_shadow[k] <= ced_cnt[k][14:8];
        end
        if (hi_rd[k]) begin
          ced_cnt[k] <= {14'b0, cnt_inc[k]};
        end else if (cnt_inc[k]) begin
          ced_cnt[k] <= ced_cnt[k] + 15'd1;
        end
      end
    end
  end

  assign i2c.scdc_i2c_rdata   = rdata_q;
  assign TMDS_Bit_clock_Ratio = tmds_config[1];
  assign scrambling_en        = tmds_config[0];
  assign update_pending       = |update_0;

endmodule

// File: tb/tb_hdmi_rx_scdc_regs.sv
module tb_hdmi_rx_scdc_regs;
  localparam int NUM_CH = 3;
  localparam int SINK_VER = 8'h01;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hdmi_rx_scdc_regs_if bus ();
  logic              in_5v_power;
  logic              clk_det;
  logic [NUM_CH-1:0] in_lock;
  logic [NUM_CH-1:0] char_err;
  logic              scrambled_det;
  logic              ratio;
  logic              scr_en;
  logic              upd_pend;

  hdmi_rx_scdc_regs #(.NUM_CH(NUM_CH), .SINK_VERSION(8'h01)) dut (
    .scdc_i2c_clk         (clk),
    .reset                (rst),
    .i2c                  (bus),
    .in_5v_power          (in_5v_power),
    .clk_det              (clk_det),
    .in_lock              (in_lock),
    .char_err             (char_err),
    .scrambled_det        (scrambled_det),
    .TMDS_Bit_clock_Ratio (ratio),
    .scrambling_en        (scr_en),
    .update_pending       (upd_pend)
  );

  // Reference model state (plain integers).
  int m_cnt [4];
  int m_shadow [4];
  int m_st, m_ced, m_src, m_cfg, m_prev_flags, m_rdata;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int flags_now();
    int f;
    f = int'(clk_det);
    for (int k = 0; k < NUM_CH; k++) f += int'(in_lock[k]) << (1 + k);
    return f;
  endfunction

  function automatic int m_read(input int a);
    int k;
    case (a)
      8'h01: return SINK_VER;
      8'h02: return m_src;
      8'h10: return m_ced * 2 + m_st;
      8'h20: return m_cfg;
      8'h21: return int'(scrambled_det);
      8'h40: return flags_now();
      default: begin
        if (a >= 8'h50 && a < 8'h50 + 2 * NUM_CH) begin
          k = (a - 8'h50) / 2;
          if ((a % 2) == 0) return m_cnt[k] % 256;
          return int'(in_lock[k]) * 128 + m_shadow[k];
        end
        return 0;
      end
    endcase
  endfunction

  task automatic chk_outs();
    check("ratio", ratio, (m_cfg / 2) % 2);
    check("scr_en", scr_en, m_cfg % 2);
    check("upd_pend", upd_pend, (m_st != 0 || m_ced != 0) ? 1 : 0);
  endtask

  // One clock: advance the model from the current inputs, take the edge,
  // commit, drop the strobes/pulses and check the outputs.
  task automatic cyc();
    int a, wd, n_cnt[4], n_sh[4], n_st, n_ced, n_src, n_cfg, n_rd, clr;
    bit rd, wr, any_inc, hit, inc;
    a = int'(bus.scdc_i2c_addr);
    wd = int'(bus.scdc_i2c_wdata);
    rd = bus.scdc_i2c_r;
    wr = bus.scdc_i2c_w;
    n_rd = rd ? m_read(a) : m_rdata;
    any_inc = 0;
    for (int k = 0; k < 4; k++) begin
      n_cnt[k] = m_cnt[k];
      n_sh[k] = m_shadow[k];
      if (k < NUM_CH) begin
        hit = char_err[k] && in_lock[k];
        inc = hit && ((rd && a == 8'h51 + 2 * k) || m_cnt[k] < 32767);
        if (inc) any_inc = 1;
        if (rd && a == 8'h50 + 2 * k) n_sh[k] = m_cnt[k] / 256;
        if (rd && a == 8'h51 + 2 * k) n_cnt[k] = inc ? 1 : 0;
        else n_cnt[k] = m_cnt[k] + (inc ? 1 : 0);
      end
    end
    clr = (wr && a == 8'h10) ? wd % 4 : 0;
    n_st = (flags_now() != m_prev_flags || (m_st != 0 && clr % 2 == 0)) ? 1 : 0;
    n_ced = (any_inc || (m_ced != 0 && clr / 2 == 0)) ? 1 : 0;
    n_src = m_src;
    n_cfg = m_cfg;
    if (!in_5v_power) begin
      n_src = 0;
      n_cfg = 0;
    end else begin
      if (wr && a == 8'h02) n_src = wd;
      if (wr && a == 8'h20) n_cfg = wd % 4;
    end
    m_prev_flags = flags_now();
    @(posedge clk);
    #1;
    m_cnt = n_cnt;
    m_shadow = n_sh;
    m_st = n_st;
    m_ced = n_ced;
    m_src = n_src;
    m_cfg = n_cfg;
    m_rdata = n_rd;
    bus.scdc_i2c_w = 1'b0;
    bus.scdc_i2c_r = 1'b0;
    char_err = '0;
    chk_outs();
  endtask

  task automatic rd(input int a, input string tag, input int lit);
    bus.scdc_i2c_addr = 8'(a);
    bus.scdc_i2c_r = 1'b1;
    cyc();
    check({tag, "_model"}, bus.scdc_i2c_rdata, m_rdata);
    if (lit >= 0) check(tag, bus.scdc_i2c_rdata, lit);
  endtask

  task automatic wr(input int a, input int d);
    bus.scdc_i2c_addr = 8'(a);
    bus.scdc_i2c_wdata = 8'(d);
    bus.scdc_i2c_w = 1'b1;
    cyc();
  endtask

  task automatic pulses(input int lane, input int n);
    for (int i = 0; i < n; i++) begin
      char_err[lane] = 1'b1;
      cyc();
    end
  endtask

  initial begin
    int addrs [14];
    addrs = '{8'h01, 8'h02, 8'h10, 8'h20, 8'h21, 8'h40, 8'h50,
              8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h77};
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0;
      m_shadow[k] = 0;
    end
    m_st = 0; m_ced = 0; m_src = 0; m_cfg = 0; m_prev_flags = 0; m_rdata = 0;
    rst = 1'b1;
    bus.scdc_i2c_addr = 8'h00;
    bus.scdc_i2c_wdata = 8'h00;
    bus.scdc_i2c_w = 1'b0;
    bus.scdc_i2c_r = 1'b0;
    in_5v_power = 1'b0;
    clk_det = 1'b0;
    in_lock = '0;
    char_err = '0;
    scrambled_det = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_rdata", bus.scdc_i2c_rdata, 0);
    check("rst_ratio", ratio, 0);
    check("rst_scr_en", scr_en, 0);
    check("rst_upd_pend", upd_pend, 0);
    rd(8'h01, "sink_ver", 8'h01);
    rd(8'h20, "tmds_cfg_rst", 8'h00);
    rd(8'h10, "update0_rst", 8'h00);

    // TMDS_Config and +5V gating
    in_5v_power = 1'b1;
    cyc();
    wr(8'h20, 8'h03);
    check("cfg_ratio_on", ratio, 1);
    check("cfg_scr_on", scr_en, 1);
    in_5v_power = 1'b0;
    cyc();
    check("5v_ratio_off", ratio, 0);
    check("5v_scr_off", scr_en, 0);
    wr(8'h20, 8'h03);
    rd(8'h20, "cfg_wr_5v_low", 8'h00);
    in_5v_power = 1'b1;
    cyc();
    wr(8'h02, 8'hA5);
    rd(8'h02, "src_ver", 8'hA5);

    // Lane 1 counting and coherent read
    clk_det = 1'b1;
    in_lock = 3'b010;
    cyc();
    cyc();
    wr(8'h10, 8'h03);
    pulses(1, 5);
    rd(8'h52, "l1_lo", 8'h05);
    rd(8'h53, "l1_hi", 8'h80);
    rd(8'h10, "ced_upd_set", 8'h02);
    rd(8'h52, "l1_lo_cleared", 8'h00);
    wr(8'h10, 8'h02);
    rd(8'h10, "ced_w1c", 8'h00);
    check("upd_pend_clr", upd_pend, 0);

    // Unlocked lane 0 ignores errors
    pulses(0, 10);
    rd(8'h50, "l0_unlocked", 8'h00);
    rd(8'h10, "l0_unlocked_ced", 8'h00);

    // Lane 2 saturation
    in_lock[2] = 1'b1;
    cyc();
    wr(8'h10, 8'h03);
    pulses(2, 32766);
    rd(8'h54, "l2_7ffe_lo", 8'hFE);
    pulses(2, 3);
    wr(8'h10, 8'h03);
    pulses(2, 2);
    rd(8'h10, "sat_no_ced", 8'h00);
    rd(8'h54, "l2_sat_lo", 8'hFF);
    rd(8'h55, "l2_sat_hi", 8'hFF);
    rd(8'h54, "l2_sat_cleared", 8'h00);

    // Shadow coherence on lane 0
    in_lock[0] = 1'b1;
    cyc();
    pulses(0, 255);
    rd(8'h50, "l0_ff_lo", 8'hFF);
    pulses(0, 1);
    rd(8'h51, "l0_shadow_hi", 8'h80);
    rd(8'h50, "l0_after_clr", 8'h00);
    char_err[0] = 1'b1;
    rd(8'h51, "l0_hi_with_err", 8'h80);
    rd(8'h50, "l0_clr_plus_err", 8'h01);

    // Status_Update timing and set-over-clear priority
    wr(8'h10, 8'h03);
    rd(8'h10, "upd_cleared", 8'h00);
    in_lock[2] = 1'b0;
    cyc();
    wr(8'h10, 8'h03);
    rd(8'h10, "upd_cleared2", 8'h00);
    in_lock[2] = 1'b1;
    check("st_not_yet", upd_pend, 0);
    cyc();
    check("st_one_later", upd_pend, 1);
    rd(8'h10, "st_set", 8'h01);
    in_lock[2] = 1'b0;
    bus.scdc_i2c_addr = 8'h10;
    bus.scdc_i2c_wdata = 8'h01;
    bus.scdc_i2c_w = 1'b1;
    cyc();
    rd(8'h10, "set_beats_w1c", 8'h01);
    wr(8'h10, 8'h01);
    rd(8'h10, "st_w1c", 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) in_lock[$urandom_range(NUM_CH - 1)] ^= 1'b1;
      if ($urandom_range(31) == 0) clk_det = ~clk_det;
      if ($urandom_range(63) == 0) in_5v_power = ~in_5v_power;
      scrambled_det = 1'($urandom_range(1));
      char_err = NUM_CH'($urandom);
      bus.scdc_i2c_addr = 8'(addrs[$urandom_range(13)]);
      bus.scdc_i2c_wdata = 8'($urandom);
      bus.scdc_i2c_w = ($urandom_range(3) == 0);
      bus.scdc_i2c_r = ($urandom_range(1) == 0);
      if (bus.scdc_i2c_r) begin
        cyc();
        check("rand_rdata", bus.scdc_i2c_rdata, m_rdata);
      end else begin
        cyc();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
